// File: rtl/traffic_light_monitor.sv
// Passive checker for the traffic_light_controller2 light/sensor interface.
// Optional first-error capture ports are enabled by defining MON_FIRST_ERR_EN.
module traffic_light_monitor #(
  parameter int unsigned YEL_CYC    = 2,
  parameter int unsigned STARVE_MAX = 20,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             e_left_sensor,
  input  logic             e_str_sensor,
  input  logic             w_left_sensor,
  input  logic             w_str_sensor,
  input  logic             ns_sensor,
  input  logic [1:0]       e_left_light,
  input  logic [1:0]       e_str_light,
  input  logic [1:0]       w_left_light,
  input  logic [1:0]       w_str_light,
  input  logic [1:0]       ns_light,
  output logic             conflict_err,
  output logic [4:0]       seq_err,
  output logic [4:0]       starve_err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             mon_ok
`ifdef MON_FIRST_ERR_EN
  ,
  output logic [2:0]       first_err_dir,
  output logic [1:0]       first_err_type
`endif
);

  localparam logic [1:0] ColRed    = 2'd0;
  localparam logic [1:0] ColGreen  = 2'd1;
  localparam logic [1:0] ColYellow = 2'd2;

  localparam int unsigned DW = $clog2(YEL_CYC + 2);
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  localparam logic [DW-1:0] YelLim    = DW'(YEL_CYC);
  localparam logic [DW-1:0] DwellMax  = DW'(YEL_CYC + 1);
  localparam logic [SW-1:0] StarveLim = SW'(STARVE_MAX);

  // Direction index order: 0 e_left, 1 e_str, 2 w_left, 3 w_str, 4 ns
  logic [1:0] light [5];
  logic [4:0] sensor;

  assign light[0] = e_left_light;
  assign light[1] = e_str_light;
  assign light[2] = w_left_light;
  assign light[3] = w_str_light;
  assign light[4] = ns_light;
  assign sensor   = {ns_sensor, w_str_sensor, w_left_sensor, e_str_sensor, e_left_sensor};

  logic [1:0]    prev_q   [5];
  logic [DW-1:0] dwell_q  [5];
  logic [DW-1:0] dwell_d  [5];
  logic [SW-1:0] starve_q [5];
  logic [SW-1:0] starve_d [5];

  logic [4:0]       nonred;
  logic [4:0]       trans_ok;
  logic [4:0]       long_stay;
  logic [4:0]       short_stay;
  logic             conflict_d;
  logic [4:0]       conflict_dirs;
  logic [4:0]       seq_d;
  logic [4:0]       starve_err_d;
  logic [3:0]       err_sum;
  logic [CNT_W:0]   cnt_sum;
  logic [CNT_W-1:0] err_cnt_d;

  always_comb begin
    nonred       = '0;
    trans_ok     = '0;
    long_stay    = '0;
    short_stay   = '0;
    seq_d        = '0;
    starve_err_d = '0;
    for (int d = 0; d < 5; d++) begin
      dwell_d[d]  = '0;
      starve_d[d] = '0;
      nonred[d]   = (light[d] != ColRed);

      case (prev_q[d])
        ColRed:    trans_ok[d] = (light[d] == ColRed)    || (light[d] == ColGreen);
        ColGreen:  trans_ok[d] = (light[d] == ColGreen)  || (light[d] == ColYellow);
        ColYellow: trans_ok[d] = (light[d] == ColYellow) || (light[d] == ColRed);
        default:   trans_ok[d] = 1'b0;
      endcase

      // Dwell saturates at YEL_CYC+1 so an overstay is reported once and the
      // eventual yellow->red of that episode is not reported again.
      if (light[d] == ColYellow) begin
        if (prev_q[d] == ColYellow) begin
          dwell_d[d] = (dwell_q[d] == DwellMax) ? DwellMax : dwell_q[d] + 1'b1;
        end else begin
          dwell_d[d] = DW'(1);
        end
        long_stay[d] = (dwell_d[d] == DwellMax) && (dwell_q[d] != DwellMax);
      end
      short_stay[d] = (prev_q[d] == ColYellow) && (light[d] == ColRed) && (dwell_q[d] < YelLim);
      seq_d[d]      = !trans_ok[d] || long_stay[d] || short_stay[d];

      if (sensor[d] && (light[d] == ColRed)) begin
        starve_d[d]     = (starve_q[d] == StarveLim) ? starve_q[d] : starve_q[d] + 1'b1;
        starve_err_d[d] = (starve_d[d] == StarveLim) && (starve_q[d] != StarveLim);
      end
    end

    conflict_dirs[0] = nonred[0] && (nonred[3] || nonred[4]);
    conflict_dirs[1] = nonred[1] && (nonred[2] || nonred[4]);
    conflict_dirs[2] = nonred[2] && (nonred[1] || nonred[4]);
    conflict_dirs[3] = nonred[3] && (nonred[0] || nonred[4]);
    conflict_dirs[4] = nonred[4] && (|nonred[3:0]);
    conflict_d       = |conflict_dirs;

    err_sum   = 4'(conflict_d) + 4'($countones(seq_d)) + 4'($countones(starve_err_d));
    cnt_sum   = {1'b0, err_cnt} + (CNT_W + 1)'(err_sum);
    err_cnt_d = cnt_sum[CNT_W] ? {CNT_W{1'b1}} : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      conflict_err <= 1'b0;
      seq_err      <= '0;
      starve_err   <= '0;
      err_cnt      <= '0;
      mon_ok       <= 1'b1;
      for (int d = 0; d < 5; d++) begin
        prev_q[d]   <= ColRed;
        dwell_q[d]  <= '0;
        starve_q[d] <= '0;
      end
    end else begin
      conflict_err <= conflict_d;
      seq_err      <= seq_d;
      starve_err   <= starve_err_d;
      err_cnt      <= err_cnt_d;
      mon_ok       <= (err_cnt_d == '0);
      for (int d = 0; d < 5; d++) begin
        prev_q[d]   <= light[d];
        dwell_q[d]  <= dwell_d[d];
        starve_q[d] <= starve_d[d];
      end
    end
  end

`ifdef MON_FIRST_ERR_EN
  logic [2:0] first_dir_d;
  logic [1:0] first_type_d;

  function automatic logic [2:0] lowest_dir(input logic [4:0] v);
    lowest_dir = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (v[i]) lowest_dir = 3'(i);
    end
  endfunction

  always_comb begin
    first_dir_d  = first_err_dir;
    first_type_d = first_err_type;
    if (first_err_type == 2'd0) begin
      if (conflict_d) begin
        first_type_d = 2'd1;
        first_dir_d  = lowest_dir(conflict_dirs);
      end else if (|seq_d) begin
        first_type_d = 2'd2;
        first_dir_d  = lowest_dir(seq_d);
      end else if (|starve_err_d) begin
        first_type_d = 2'd3;
        first_dir_d  = lowest_dir(starve_err_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      first_err_dir  <= '0;
      first_err_type <= '0;
    end else begin
      first_err_dir  <= first_dir_d;
      first_err_type <= first_type_d;
    end
  end
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed scoreboard bench for traffic_light_monitor (default parameters).
module tb_traffic_light_monitor;

  localparam logic [1:0] R = 2'd0;
  localparam logic [1:0] G = 2'd1;
  localparam logic [1:0] Y = 2'd2;
  localparam logic [1:0] U = 2'd3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] sen = '0;
  logic [9:0] lts = '0;

  logic       conflict_err;
  logic [4:0] seq_err;
  logic [4:0] starve_err;
  logic [7:0] err_cnt;
  logic       mon_ok;
`ifdef MON_FIRST_ERR_EN
  logic [2:0] first_err_dir;
  logic [1:0] first_err_type;
`endif

  traffic_light_monitor dut (
    .clk           (clk),
    .reset         (reset),
    .e_left_sensor (sen[0]),
    .e_str_sensor  (sen[1]),
    .w_left_sensor (sen[2]),
    .w_str_sensor  (sen[3]),
    .ns_sensor     (sen[4]),
    .e_left_light  (lts[1:0]),
    .e_str_light   (lts[3:2]),
    .w_left_light  (lts[5:4]),
    .w_str_light   (lts[7:6]),
    .ns_light      (lts[9:8]),
    .conflict_err  (conflict_err),
    .seq_err       (seq_err),
    .starve_err    (starve_err),
    .err_cnt       (err_cnt),
`ifdef MON_FIRST_ERR_EN
    .first_err_dir (first_err_dir),
    .first_err_type(first_err_type),
`endif
    .mon_ok        (mon_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       conf;
    logic [4:0] seq;
    logic [4:0] stv;
    logic [7:0] cnt;
    logic       ok;
  } exp_t;

  exp_t        sb[$];
  int unsigned passed = 0;
  int unsigned failed = 0;
  int unsigned total  = 0;
  int          exp_cnt = 0;

  function automatic logic [9:0] lv(input logic [1:0] ns, input logic [1:0] ws,
                                    input logic [1:0] wl, input logic [1:0] es,
                                    input logic [1:0] el);
    return {ns, ws, wl, es, el};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      failed++;
      $error("FAIL %s observed=empty_scoreboard expected=entry", tag);
      return;
    end
    e = sb.pop_front();
    check({tag, ".conflict"}, 8'(conflict_err), 8'(e.conf));
    check({tag, ".seq"},      8'(seq_err),      8'(e.seq));
    check({tag, ".starve"},   8'(starve_err),   8'(e.stv));
    check({tag, ".cnt"},      err_cnt,          e.cnt);
    check({tag, ".ok"},       8'(mon_ok),       8'(e.ok));
  endtask

  task automatic step(input logic [9:0] l, input logic [4:0] s, input logic c,
                      input logic [4:0] sq, input logic [4:0] sv, input string tag);
    @(negedge clk);
    reset = 1'b0;
    lts   = l;
    sen   = s;
    exp_cnt = exp_cnt + int'(c) + $countones(sq) + $countones(sv);
    if (exp_cnt > 255) exp_cnt = 255;
    sb.push_back('{c, sq, sv, exp_cnt[7:0], exp_cnt == 0});
    @(posedge clk);
    #1;
    compare(tag);
  endtask

  task automatic do_reset(input int n, input logic [9:0] l, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      reset = 1'b1;
      lts   = l;
      sen   = '0;
      exp_cnt = 0;
      sb.push_back('{1'b0, 5'b0, 5'b0, 8'd0, 1'b1});
      @(posedge clk);
      #1;
      compare(tag);
    end
  endtask

  initial begin
    // Idle: everything red, no traffic
    do_reset(2, '0, "rst");
    for (int i = 0; i < 50; i++) step('0, '0, 1'b0, 5'b0, 5'b0, "idle");

    // Legal e_left cycle with exact yellow dwell
    do_reset(1, '0, "rst2");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b0, 5'b0, "el_red");
    step(lv(R, R, R, R, G), '0, 1'b0, 5'b0, 5'b0, "el_grn");
    step(lv(R, R, R, R, Y), '0, 1'b0, 5'b0, 5'b0, "el_y1");
    step(lv(R, R, R, R, Y), '0, 1'b0, 5'b0, 5'b0, "el_y2");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b0, 5'b0, "el_red2");

    // e_left and ns green together
    do_reset(1, '0, "rst3");
    step(lv(G, R, R, R, G), '0, 1'b1, 5'b0, 5'b0, "conf");
`ifdef MON_FIRST_ERR_EN
    check("first_type", 8'(first_err_type), 8'd1);
    check("first_dir",  8'(first_err_dir),  8'd0);
`endif

    // w_str green->red, then ns overstays yellow
    do_reset(1, '0, "rst4");
    step(lv(R, G, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ws_grn");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b01000, 5'b0, "ws_g2r");
    step(lv(G, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ns_grn");
    step(lv(Y, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ns_y1");
    step(lv(Y, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ns_y2");
    step(lv(Y, R, R, R, R), '0, 1'b0, 5'b10000, 5'b0, "ns_y3");
    step(lv(Y, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ns_y4");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "ns_red");

    // Short yellow, red->yellow, undefined code with simultaneous conflict
    do_reset(1, '0, "rst5");
    step(lv(R, R, R, G, R), '0, 1'b0, 5'b00000, 5'b0, "es_grn");
    step(lv(R, R, R, Y, R), '0, 1'b0, 5'b00000, 5'b0, "es_y1");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b00010, 5'b0, "es_short");
    step(lv(R, R, Y, R, R), '0, 1'b0, 5'b00100, 5'b0, "wl_r2y");
    step(lv(R, R, Y, R, R), '0, 1'b0, 5'b00000, 5'b0, "wl_y2");
    step(lv(R, R, R, R, R), '0, 1'b0, 5'b00000, 5'b0, "wl_red");
    do_reset(1, '0, "rst6");
    step(lv(G, R, R, U, R), '0, 1'b1, 5'b00010, 5'b0, "undef_conf");

    // ns starvation: one pulse at cycle 20, none after
    do_reset(1, '0, "rst7");
    for (int i = 1; i <= 30; i++)
      step('0, 5'b10000, 1'b0, 5'b0, (i == 20) ? 5'b10000 : 5'b00000, "starve");
    step('0, 5'b00000, 1'b0, 5'b0, 5'b0, "starve_clr");

    // Counter saturation, then reset mid-stream
    do_reset(1, '0, "rst8");
    for (int i = 0; i < 300; i++) step(lv(G, R, R, R, G), '0, 1'b1, 5'b0, 5'b0, "sat");
    do_reset(1, lv(G, R, R, R, G), "rst_mid");
    do_reset(1, '0, "rst9");
    step('0, '0, 1'b0, 5'b0, 5'b0, "post_rst");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
